data_ram_responder: RTL and testbench
=====================================

# data_ram_responder

Data-memory responder at the far end of the CPU's memory-stage bus. It accepts the load/store request the memory stage drives (chip enable, write enable, byte address, 4-bit byte select, write data) and performs big-endian byte-lane writes or full-word reads on an internal RAM. It inserts a configurable number of wait states, returns a one-cycle acknowledge, and raises a pipeline stall while a request is pending. It sits between the memory stage and the top-level SoC, replacing the ideal zero-latency data memory.

## Interface
- ADDR_WIDTH, 10, word-address bits; depth = 2^ADDR_WIDTH 32-bit words
- WAIT_CYCLES, 1, extra cycles inserted before each access; 0..15 legal
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- ce_i  in  1  request valid (memory enable from memory stage)
- we_i  in  1  1 = write, 0 = read
- addr_i  in  32  byte address; bits [1:0] ignored (lanes given by sel_i)
- sel_i  in  4  byte select; sel_i[3] ↔ data[31:24] (offset 0), sel_i[0] ↔ data[7:0] (offset 3)
- data_i  in  32  write data, already lane-replicated by requester
- data_o  out  32  read data, full word, held until next ack
- ack_o  out  1  one-cycle completion pulse
- err_o  out  1  out-of-range flag, valid only with ack_o
- stall_o  out  1  pipeline stall request

## Operation
- Word index = addr_i[ADDR_WIDTH+1:2]. Out of range if addr_i[31:ADDR_WIDTH+2] != 0: no write, data_o <= 0, err_o = 1 with ack_o.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: ce_i=1 → capture we/addr/sel/data, cnt <= WAIT_CYCLES, go WAIT; else stay.
  - WAIT: cnt != 0 → cnt--. cnt == 0 → perform access on this edge, go DONE.
  - DONE: ack_o = 1; unconditionally go IDLE. ce_i is ignored in DONE.
- Write: only lanes with sel_i bit set are updated; others are preserved. sel_i = 0000 with we=1 completes and acks, with no change to memory.
- Read: data_o <= full stored word regardless of sel_i; the memory stage does lane extraction and sign extension.
- A captured request always completes. ce_i or inputs changing during WAIT have no effect.
- stall_o = (IDLE & ce_i) | WAIT. Low in DONE, so the pipeline advances on the ack cycle.
- RAM contents are not reset and are undefined at power-up.

## Timing
- Request seen in IDLE at cycle T → ack_o high in cycle T+2+WAIT_CYCLES. Write is visible to a read accepted in cycle T+3+WAIT_CYCLES or later.
- Back-to-back requests: the next request is accepted the cycle after DONE. Throughput is one access per 3+WAIT_CYCLES cycles.
- Reset values: state IDLE, cnt 0, data_o 0, ack_o 0, err_o 0, stall_o 0 (combinationally 1 if ce_i is high in IDLE after reset).
- Reset mid-WAIT: the pending access is aborted (no write), the FSM returns to IDLE, and RAM is untouched. Reset in DONE clears ack_o next cycle.
- rst and ce_i high together: reset wins, and the request is not captured.

## Structure
- Shared package (e.g. mem_bus_pkg): FSM state encoding, SEL_* lane constants (SEL_B0=4'b1000 … SEL_W=4'b1111), MAX_WAIT=15.
- Sub-module dram_bank: four byte-wide arrays of 2^ADDR_WIDTH entries, with a synchronous per-lane write enable and synchronous word read. The top level holds the FSM, capture registers, range check and stall logic.

## Test plan
- WAIT_CYCLES=1, SW addr 0x10, sel 1111, data 0xDEADBEEF → stall_o high for T, T+1, T+2 exclusive of the ack cycle; ack_o at T+3. Then LW 0x10 → data_o 0xDEADBEEF.
- SB addr 0x11 (sel 0100, data 0x5A5A5A5A) over word 0x11223344, then read 0x10 → 0x115A3344.
- SH sel 0011 data 0xABCDABCD over 0x00000000, then read → 0x0000ABCD.
- Read addr 0x0000_1000 with ADDR_WIDTH=10 → ack_o with err_o=1, data_o=0; the following in-range read gives err_o=0.
- SW 0x20 data 0x12345678, rst pulsed during WAIT (WAIT_CYCLES=3) → no ack; a subsequent read of 0x20 returns the prior contents.
- WAIT_CYCLES=0, ce_i held high for 3 requests → acks at T+2, T+5, T+8; ce_i in DONE is not double-accepted.

Source files
------------

// File: rtl/data_ram_responder_pkg.sv
// data_ram_responder_pkg: shared FSM encoding, byte-lane select constants and wait-state limits for the data RAM responder
package data_ram_responder_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  localparam logic [3:0] SEL_B0 = 4'b1000;
  localparam logic [3:0] SEL_B1 = 4'b0100;
  localparam logic [3:0] SEL_B2 = 4'b0010;
  localparam logic [3:0] SEL_B3 = 4'b0001;
  localparam logic [3:0] SEL_H0 = 4'b1100;
  localparam logic [3:0] SEL_H1 = 4'b0011;
  localparam logic [3:0] SEL_W  = 4'b1111;
  localparam int MAX_WAIT = 15;
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
endpackage

// File: rtl/data_ram_responder_dram_bank.sv
// data_ram_responder_dram_bank: four byte-wide RAM lanes; clk, we[3:0] per-lane write (we[3] = data[31:24]), re word read, addr word index, wdata in, rdata registered out
module data_ram_responder_dram_bank #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic [3:0]            we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);
  for (genvar b = 0; b < 4; b++) begin : g_lane
    logic [7:0] mem [2**ADDR_WIDTH];
    logic [7:0] rd_q;
    always_ff @(posedge clk) begin
      if (we[b]) mem[addr] <= wdata[8*b +: 8];
      if (re) rd_q <= mem[addr];
    end
    assign rdata[8*b +: 8] = rd_q;
  end
endmodule

// File: rtl/data_ram_responder.sv
// data_ram_responder: wait-stated big-endian data RAM; clk/rst, request ce_i/we_i/addr_i/sel_i/data_i, response data_o/ack_o/err_o, stall_o while pending
module data_ram_responder
  import data_ram_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        stall_o
);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             we_q;
  logic [29:0]      addr_q;
  logic [3:0]       sel_q;
  logic [31:0]      wdata_q;
  logic             zero_q;
  logic             go, oor;
  logic [31:0]      bank_rdata;
  logic             unused_addr;
  assign unused_addr = ^addr_i[1:0];
  assign go  = (state_q == WAIT) && (cnt_q == '0);
  assign oor = |addr_q[29:ADDR_WIDTH];
  always_comb begin
    state_d = (state_q == IDLE) ? (ce_i ? WAIT : IDLE) :
              (state_q == WAIT) ? ((cnt_q == '0) ? DONE : WAIT) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && ce_i) begin
        we_q    <= we_i;
        addr_q  <= addr_i[31:2];
        sel_q   <= sel_i;
        wdata_q <= data_i;
        cnt_q   <= CNT_W'(WAIT_CYCLES);
      end else if (state_q == WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
      // data_o is masked to zero after an out-of-range access; in-range writes leave the last read word visible
      if (go && (oor || !we_q)) zero_q <= oor;
    end
  end
  data_ram_responder_dram_bank #(.ADDR_WIDTH(ADDR_WIDTH)) u_bank (
    .clk   (clk),
    .we    ({4{go && we_q && !oor}} & sel_q),
    .re    (go && !we_q && !oor),
    .addr  (addr_q[ADDR_WIDTH-1:0]),
    .wdata (wdata_q),
    .rdata (bank_rdata)
  );
  assign data_o  = zero_q ? 32'h0 : bank_rdata;
  assign ack_o   = (state_q == DONE);
  assign err_o   = (state_q == DONE) && oor;
  assign stall_o = ((state_q == IDLE) && ce_i) || (state_q == WAIT);
endmodule

// File: tb/tb_data_ram_responder.sv
// tb_data_ram_responder: directed bench for data_ram_responder at WAIT_CYCLES 1, 3 and 0
module tb_data_ram_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        ce [3];
  logic        we [3];
  logic [31:0] addr [3];
  logic [3:0]  sel [3];
  logic [31:0] wd [3];
  logic [31:0] rd [3];
  logic        ack [3];
  logic        err [3];
  logic        stall [3];
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  data_ram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(1)) dut0 (
    .clk(clk), .rst(rst), .ce_i(ce[0]), .we_i(we[0]), .addr_i(addr[0]), .sel_i(sel[0]),
    .data_i(wd[0]), .data_o(rd[0]), .ack_o(ack[0]), .err_o(err[0]), .stall_o(stall[0]));
  data_ram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst), .ce_i(ce[1]), .we_i(we[1]), .addr_i(addr[1]), .sel_i(sel[1]),
    .data_i(wd[1]), .data_o(rd[1]), .ack_o(ack[1]), .err_o(err[1]), .stall_o(stall[1]));
  data_ram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut2 (
    .clk(clk), .rst(rst), .ce_i(ce[2]), .we_i(we[2]), .addr_i(addr[2]), .sel_i(sel[2]),
    .data_i(wd[2]), .data_o(rd[2]), .ack_o(ack[2]), .err_o(err[2]), .stall_o(stall[2]));
  // Issues one request in cycle T and waits (bounded) for its ack; stl[n] is stall_o in cycle T+n
  task automatic do_req(input int k, input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, output int lat, output logic e, output logic [31:0] q,
                        output logic [3:0] stl);
    lat = -1; e = 1'bx; q = 'x; stl = '0;
    @(negedge clk);
    ce[k] = 1'b1; we[k] = w; addr[k] = a; sel[k] = s; wd[k] = d;
    #1 stl[0] = stall[k];
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      ce[k] = 1'b0;
      #1;
      if (n < 4) stl[n] = stall[k];
      if (ack[k]) begin
        lat = n; e = err[k]; q = rd[k];
        break;
      end
    end
  endtask
  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    tests++; if (ack[0] !== 1'b0) begin fails++; $display("FAIL reset_ack got %b want 0", ack[0]); end
    tests++; if (err[0] !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", err[0]); end
    tests++; if (stall[0] !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", stall[0]); end
    tests++; if (rd[0] !== 32'h0) begin fails++; $display("FAIL reset_data got %h want 00000000", rd[0]); end
    ce[0] = 1'b1;
    #1;
    tests++; if (stall[0] !== 1'b1) begin fails++; $display("FAIL idle_ce_stall got %b want 1", stall[0]); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; ce[0] = 1'b0;
    #1;
    tests++; if (stall[0] !== 1'b0) begin fails++; $display("FAIL rst_ce_not_captured stall got %b want 0", stall[0]); end
    repeat (4) begin
      @(negedge clk); #1;
      tests++; if (ack[0] !== 1'b0) begin fails++; $display("FAIL rst_ce_no_ack got %b want 0", ack[0]); end
    end
  endtask
  task automatic test_word;
    int lat; logic e; logic [31:0] q; logic [3:0] stl;
    do_req(0, 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, lat, e, q, stl);
    tests++; if (lat !== 3) begin fails++; $display("FAIL sw_latency got %0d want 3", lat); end
    tests++; if (stl !== 4'b0111) begin fails++; $display("FAIL sw_stall got %b want 0111", stl); end
    tests++; if (e !== 1'b0) begin fails++; $display("FAIL sw_err got %b want 0", e); end
    do_req(0, 1'b0, 32'h10, 4'b0000, 32'h0, lat, e, q, stl);
    tests++; if (lat !== 3) begin fails++; $display("FAIL lw_latency got %0d want 3", lat); end
    tests++; if (q !== 32'hDEADBEEF) begin fails++; $display("FAIL lw_data got %h want deadbeef", q); end
    @(negedge clk); #1;
    tests++; if (rd[0] !== 32'hDEADBEEF) begin fails++; $display("FAIL lw_hold got %h want deadbeef", rd[0]); end
  endtask
  task automatic test_byte;
    int lat; logic e; logic [31:0] q; logic [3:0] stl;
    do_req(0, 1'b1, 32'h10, 4'b1111, 32'h11223344, lat, e, q, stl);
    do_req(0, 1'b1, 32'h11, 4'b0100, 32'h5A5A5A5A, lat, e, q, stl);
    do_req(0, 1'b0, 32'h10, 4'b1111, 32'h0, lat, e, q, stl);
    tests++; if (q !== 32'h115A3344) begin fails++; $display("FAIL sb_merge got %h want 115a3344", q); end
  endtask
  task automatic test_half;
    int lat; logic e; logic [31:0] q; logic [3:0] stl;
    do_req(0, 1'b1, 32'h14, 4'b1111, 32'h0, lat, e, q, stl);
    do_req(0, 1'b1, 32'h16, 4'b0011, 32'hABCDABCD, lat, e, q, stl);
    do_req(0, 1'b0, 32'h14, 4'b0000, 32'h0, lat, e, q, stl);
    tests++; if (q !== 32'h0000ABCD) begin fails++; $display("FAIL sh_merge got %h want 0000abcd", q); end
    do_req(0, 1'b1, 32'h14, 4'b0000, 32'hFFFFFFFF, lat, e, q, stl);
    tests++; if (lat !== 3) begin fails++; $display("FAIL sel0_ack latency got %0d want 3", lat); end
    do_req(0, 1'b0, 32'h14, 4'b1111, 32'h0, lat, e, q, stl);
    tests++; if (q !== 32'h0000ABCD) begin fails++; $display("FAIL sel0_nochange got %h want 0000abcd", q); end
  endtask
  task automatic test_range;
    int lat; logic e; logic [31:0] q; logic [3:0] stl;
    do_req(0, 1'b0, 32'h0000_1000, 4'b1111, 32'h0, lat, e, q, stl);
    tests++; if (lat !== 3) begin fails++; $display("FAIL oor_latency got %0d want 3", lat); end
    tests++; if (e !== 1'b1) begin fails++; $display("FAIL oor_err got %b want 1", e); end
    tests++; if (q !== 32'h0) begin fails++; $display("FAIL oor_data got %h want 00000000", q); end
    do_req(0, 1'b1, 32'h0000_1010, 4'b1111, 32'hCAFEF00D, lat, e, q, stl);
    tests++; if (e !== 1'b1) begin fails++; $display("FAIL oor_wr_err got %b want 1", e); end
    do_req(0, 1'b0, 32'h10, 4'b1111, 32'h0, lat, e, q, stl);
    tests++; if (e !== 1'b0) begin fails++; $display("FAIL inrange_err got %b want 0", e); end
    tests++; if (q !== 32'h115A3344) begin fails++; $display("FAIL oor_no_alias_write got %h want 115a3344", q); end
  endtask
  task automatic test_reset_wait;
    int lat; logic e; logic [31:0] q; logic [3:0] stl;
    do_req(1, 1'b1, 32'h20, 4'b1111, 32'hAAAA5555, lat, e, q, stl);
    tests++; if (lat !== 5) begin fails++; $display("FAIL w3_latency got %0d want 5", lat); end
    @(negedge clk);
    ce[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h20; sel[1] = 4'b1111; wd[1] = 32'h12345678;
    @(negedge clk);
    ce[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++; if (stall[1] !== 1'b0) begin fails++; $display("FAIL rst_wait_stall got %b want 0", stall[1]); end
    repeat (6) begin
      @(negedge clk); #1;
      tests++; if (ack[1] !== 1'b0) begin fails++; $display("FAIL rst_wait_no_ack got %b want 0", ack[1]); end
    end
    do_req(1, 1'b0, 32'h20, 4'b1111, 32'h0, lat, e, q, stl);
    tests++; if (q !== 32'hAAAA5555) begin fails++; $display("FAIL rst_wait_ram got %h want aaaa5555", q); end
  endtask
  task automatic test_back_to_back;
    int lat; logic e; logic [31:0] q; logic [3:0] stl;
    logic [9:0] ack_m, stall_m;
    do_req(2, 1'b1, 32'h40, 4'b1111, 32'h0BADCAFE, lat, e, q, stl);
    tests++; if (lat !== 2) begin fails++; $display("FAIL w0_latency got %0d want 2", lat); end
    ack_m = '0; stall_m = '0;
    @(negedge clk);
    ce[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'h40; sel[2] = 4'b1111;
    for (int n = 0; n < 10; n++) begin
      if (n > 0) @(negedge clk);
      if (n == 9) ce[2] = 1'b0;
      #1;
      ack_m[n] = ack[2];
      stall_m[n] = stall[2];
      if (n == 2) begin
        tests++; if (rd[2] !== 32'h0BADCAFE) begin fails++; $display("FAIL b2b_data got %h want 0badcafe", rd[2]); end
      end
    end
    tests++; if (ack_m !== 10'b01_0010_0100) begin fails++; $display("FAIL b2b_ack got %b want 0100100100", ack_m); end
    tests++; if (stall_m !== 10'b00_1101_1011) begin fails++; $display("FAIL b2b_stall got %b want 0011011011", stall_m); end
    @(negedge clk); #1;
    tests++; if (stall[2] !== 1'b0) begin fails++; $display("FAIL b2b_idle_stall got %b want 0", stall[2]); end
  endtask
  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ce[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; sel[k] = '0; wd[k] = '0;
    end
    test_reset;
    test_word;
    test_byte;
    test_half;
    test_range;
    test_reset_wait;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
